// File: rtl/y_update_sequencer_if.sv
// Handshake and Y SRAM bus bundle between the Y-update sequencer and its neighbours.
// master: the side driving start/done flags and SRAM requests; slave: the sequencer.
interface y_update_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int ITER_W = 8
);
  logic              in_start;
  logic              in_updateYCtrlPathDoneFlag;
  logic              in_updateYwriteDoneFlag;
  logic [ADDR_W-1:0] in_updYAddr;
  logic              in_updYWe;
  logic [DATA_W-1:0] in_updYWdata;
  logic [ADDR_W-1:0] in_wrYAddr;
  logic              in_wrYWe;
  logic [DATA_W-1:0] in_wrYWdata;
  logic [ADDR_W-1:0] op_sramAddr;
  logic              op_sramWe;
  logic [DATA_W-1:0] op_sramWdata;
  logic              op_updateYmoduleEnable;
  logic              op_writeYvalEnable;
  logic [ITER_W-1:0] op_iterCount;
  logic              op_busy;
  logic              op_done;
  logic              op_error;

  modport master (
    output in_start, in_updateYCtrlPathDoneFlag, in_updateYwriteDoneFlag,
    output in_updYAddr, in_updYWe, in_updYWdata,
    output in_wrYAddr, in_wrYWe, in_wrYWdata,
    input  op_sramAddr, op_sramWe, op_sramWdata,
    input  op_updateYmoduleEnable, op_writeYvalEnable, op_iterCount,
    input  op_busy, op_done, op_error
  );

  modport slave (
    input  in_start, in_updateYCtrlPathDoneFlag, in_updateYwriteDoneFlag,
    input  in_updYAddr, in_updYWe, in_updYWdata,
    input  in_wrYAddr, in_wrYWe, in_wrYWdata,
    output op_sramAddr, op_sramWe, op_sramWdata,
    output op_updateYmoduleEnable, op_writeYvalEnable, op_iterCount,
    output op_busy, op_done, op_error
  );
endinterface

// File: rtl/y_update_sequencer.sv
// Y-update loop sequencer: alternates compute and write phases NUM_ITER times per start
// and owns the single Y SRAM port. Optional per-phase watchdog under YSEQ_WATCHDOG_EN.
module y_update_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int ITER_W   = 8,
  parameter int NUM_ITER = 16,
  parameter int WDOG_CYC = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                soft_rst,
  y_update_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPUTE = 3'd1,
    S_WRITE   = 3'd2,
    S_DONE    = 3'd3,
    S_ERR     = 3'd4
  } state_e;

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NUM_ITER);

  generate
    if (NUM_ITER < 1 || NUM_ITER >= (1 << ITER_W)) begin : g_bad_num_iter
      $error("NUM_ITER must lie in 1..2^ITER_W-1");
    end
    if (WDOG_CYC < 1) begin : g_bad_wdog
      $error("WDOG_CYC must be at least 1");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              error_q, error_d;
  logic              upd_en_q;
  logic              wr_en_q;
  logic              busy_q;
  logic              done_q;

  logic              ctrl_done;
  logic              write_done;
  logic              wdog_expired;

  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;

  assign ctrl_done  = bus.in_updateYCtrlPathDoneFlag;
  assign write_done = bus.in_updateYwriteDoneFlag;

`ifdef YSEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYC + 1);
  logic [WDOG_W-1:0] wdog_q;

  // wdog_q counts cycles already spent in the current phase; the last allowed one trips it.
  assign wdog_expired = (wdog_q == WDOG_W'(WDOG_CYC - 1));
`else
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    error_d = error_q;
    if (ctrl_done && write_done) begin
      state_d = S_ERR;
      error_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (ctrl_done || write_done) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (bus.in_start) begin
            state_d = S_COMPUTE;
            iter_d  = '0;
            error_d = 1'b0;
          end
        end
        S_COMPUTE: begin
          if (write_done) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (ctrl_done) begin
            state_d = S_WRITE;
          end else if (wdog_expired) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
        S_WRITE: begin
          if (ctrl_done) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (write_done) begin
            iter_d  = iter_q + 1'b1;
            state_d = (iter_d == LAST_ITER) ? S_DONE : S_COMPUTE;
          end else if (wdog_expired) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
        default: begin
          state_d = S_ERR;
          error_d = 1'b1;
        end
      endcase
    end
  end

  // Enables, busy and done are registered from the next state so they line up with state_q.
  always_ff @(posedge clock) begin
    if (!reset || soft_rst) begin
      state_q  <= S_IDLE;
      iter_q   <= '0;
      error_q  <= 1'b0;
      upd_en_q <= 1'b0;
      wr_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef YSEQ_WATCHDOG_EN
      wdog_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      iter_q   <= iter_d;
      error_q  <= error_d;
      upd_en_q <= (state_d == S_COMPUTE);
      wr_en_q  <= (state_d == S_WRITE);
      busy_q   <= (state_d == S_COMPUTE) || (state_d == S_WRITE);
      done_q   <= (state_q == S_WRITE) && (state_d == S_DONE);
`ifdef YSEQ_WATCHDOG_EN
      if (state_d != state_q) begin
        wdog_q <= '0;
      end else if (state_q == S_COMPUTE || state_q == S_WRITE) begin
        wdog_q <= wdog_q + 1'b1;
      end
`endif
    end
  end

  // Only the active phase reaches the SRAM; the other requester is silently dropped.
  always_comb begin
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state_q)
      S_COMPUTE: begin
        sram_we    = bus.in_updYWe;
        sram_addr  = bus.in_updYAddr;
        sram_wdata = bus.in_updYWdata;
      end
      S_WRITE: begin
        sram_we    = bus.in_wrYWe;
        sram_addr  = bus.in_wrYAddr;
        sram_wdata = bus.in_wrYWdata;
      end
      default: begin
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
      end
    endcase
  end

  assign bus.op_sramWe              = sram_we;
  assign bus.op_sramAddr            = sram_addr;
  assign bus.op_sramWdata           = sram_wdata;
  assign bus.op_updateYmoduleEnable = upd_en_q;
  assign bus.op_writeYvalEnable     = wr_en_q;
  assign bus.op_iterCount           = iter_q;
  assign bus.op_busy                = busy_q;
  assign bus.op_done                = done_q;
  assign bus.op_error               = error_q;

endmodule
